// File: rtl/adxl362_spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : adxl362_spi_master
// Description : SPI mode-0 master for ADXL362 register transactions.
//               Sends a command byte, an address byte ({2'b00,address}) and
//               then `length` data bytes. Write data is pulled from the host
//               with wr_ready; read data is pushed to the host with rd_valid.
// Ports       : clk_16mhz, rst (async, active high)
//               start/command/address/length - transaction request
//               wr_data/wr_ready             - write byte handshake
//               rd_data/rd_valid             - read byte strobe
//               busy/done                    - transaction status
//               SCLK/MOSI/nCS/MISO           - SPI bus (CPOL=0, CPHA=0)
// Revision    : 1.0 - initial release
// ============================================================================
module adxl362_spi_master #(
    parameter int CLK_DIV  = 4,   // SCLK half-period in clk_16mhz cycles
    parameter int CS_SETUP = 2,   // nCS low to first SCLK activity
    parameter int CS_HOLD  = 2    // last SCLK fall to nCS high, and nCS high time
) (
    input  logic       clk_16mhz,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] command,
    input  logic [5:0] address,
    input  logic [4:0] length,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       done,
    output logic       SCLK,
    output logic       MOSI,
    output logic       nCS,
    input  logic       MISO
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_SETUP   = 3'd1;
    localparam logic [2:0] c_ST_SHIFT   = 3'd2;
    localparam logic [2:0] c_ST_NEXT    = 3'd3;
    localparam logic [2:0] c_ST_HOLD    = 3'd4;
    localparam logic [2:0] c_ST_RECOVER = 3'd5;

    localparam logic [7:0] c_DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] c_SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] c_HOLD_LAST  = 8'(CS_HOLD - 1);
    localparam logic [7:0] c_CMD_WRITE  = 8'h0A;

    logic [2:0] r_state;
    logic [7:0] r_cnt;     // shared delay / half-period counter
    logic [2:0] r_bit;     // bit index within current byte
    logic [5:0] r_byte;    // bytes completed (header + data)
    logic [7:0] r_tx;
    logic [7:0] r_rx;
    logic [7:0] r_cmd;
    logic [5:0] r_addr;
    logic [4:0] r_len;

    logic       w_is_write;
    logic       w_hdr0_done;
    logic       w_more;
    logic       w_load_data;
    logic [7:0] w_data_byte;

    assign w_is_write  = (r_cmd == c_CMD_WRITE);
    assign w_hdr0_done = (r_byte == 6'd1);
    // Another byte follows while fewer than 2+length bytes have completed.
    assign w_more      = (r_byte < ({1'b0, r_len} + 6'd2));
    assign w_load_data = (r_state == c_ST_NEXT) && !w_hdr0_done && w_more;
    assign w_data_byte = w_is_write ? wr_data : 8'h00;

    // Combinational so the host sees the strobe in the same cycle wr_data
    // is captured into the shift register.
    assign wr_ready = w_load_data && w_is_write;

    always_ff @(posedge clk_16mhz or posedge rst) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= 8'd0;
            r_bit    <= 3'd0;
            r_byte   <= 6'd0;
            r_tx     <= 8'd0;
            r_rx     <= 8'd0;
            r_cmd    <= 8'd0;
            r_addr   <= 6'd0;
            r_len    <= 5'd0;
            rd_data  <= 8'd0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            SCLK     <= 1'b0;
            MOSI     <= 1'b0;
            nCS      <= 1'b1;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    // !done rejects a start that coincides with the done strobe.
                    if (start && !busy && !done) begin
                        r_cmd   <= command;
                        r_addr  <= address;
                        r_len   <= length;
                        r_tx    <= command;
                        MOSI    <= command[7];
                        r_cnt   <= 8'd0;
                        r_bit   <= 3'd0;
                        r_byte  <= 6'd0;
                        busy    <= 1'b1;
                        nCS     <= 1'b0;
                        r_state <= c_ST_SETUP;
                    end
                end
                c_ST_SETUP: begin
                    if (r_cnt >= c_SETUP_LAST) begin
                        r_cnt   <= 8'd0;
                        r_state <= c_ST_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_ST_SHIFT: begin
                    if (r_cnt >= c_DIV_LAST) begin
                        r_cnt <= 8'd0;
                        if (!SCLK) begin
                            SCLK <= 1'b1;
                            r_rx <= {r_rx[6:0], MISO};
                        end else begin
                            SCLK <= 1'b0;
                            if (r_bit == 3'd7) begin
                                r_bit   <= 3'd0;
                                r_byte  <= r_byte + 6'd1;
                                r_state <= c_ST_NEXT;
                            end else begin
                                r_bit <= r_bit + 3'd1;
                                r_tx  <= {r_tx[6:0], 1'b0};
                                MOSI  <= r_tx[6];
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_ST_NEXT: begin
                    // This cycle counts as the first low cycle of the next
                    // byte (or of the hold time), so counting resumes at 1.
                    r_cnt <= 8'd1;
                    if ((r_byte >= 6'd3) && !w_is_write) begin
                        rd_data  <= r_rx;
                        rd_valid <= 1'b1;
                    end
                    if (w_hdr0_done) begin
                        r_tx    <= {2'b00, r_addr};
                        MOSI    <= 1'b0;
                        r_state <= c_ST_SHIFT;
                    end else if (w_more) begin
                        r_tx    <= w_data_byte;
                        MOSI    <= w_data_byte[7];
                        r_state <= c_ST_SHIFT;
                    end else begin
                        MOSI    <= 1'b0;
                        r_state <= c_ST_HOLD;
                    end
                end
                c_ST_HOLD: begin
                    if (r_cnt >= c_HOLD_LAST) begin
                        r_cnt   <= 8'd0;
                        nCS     <= 1'b1;
                        r_state <= c_ST_RECOVER;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_ST_RECOVER: begin
                    if (r_cnt >= c_HOLD_LAST) begin
                        r_cnt   <= 8'd0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adxl362_spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_adxl362_spi_master
// Description : Self-checking bench for adxl362_spi_master. A small SPI slave
//               model drives MISO; MOSI bytes, read bytes, strobe counts and
//               SCLK/nCS timing are compared against scoreboard queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adxl362_spi_master;

    localparam int CLK_DIV  = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;

    logic       clk_16mhz = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] command;
    logic [5:0] address;
    logic [4:0] length;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       done;
    logic       SCLK;
    logic       MOSI;
    logic       nCS;
    logic       MISO;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_mosi_q[$];
    logic [7:0] exp_rd_q[$];
    logic [7:0] miso_q[$];

    int n_rise = 0;
    int n_wr   = 0;
    int n_rd   = 0;
    int n_done = 0;

    always #31.25 clk_16mhz = ~clk_16mhz;

    adxl362_spi_master #(
        .CLK_DIV (CLK_DIV),
        .CS_SETUP(CS_SETUP),
        .CS_HOLD (CS_HOLD)
    ) dut (
        .clk_16mhz(clk_16mhz),
        .rst      (rst),
        .start    (start),
        .command  (command),
        .address  (address),
        .length   (length),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .done     (done),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .nCS      (nCS),
        .MISO     (MISO)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- SPI slave model (mode 0) ----------------
    logic [7:0] s_byte = 8'h00;
    int         s_bits = 0;

    function automatic logic [7:0] next_miso();
        if (miso_q.size() > 0) return miso_q.pop_front();
        return 8'h00;
    endfunction

    always @(negedge nCS) begin
        s_byte = next_miso();
        s_bits = 0;
        MISO   = s_byte[7];
    end

    always @(negedge SCLK) begin
        if (nCS === 1'b0) begin
            s_bits++;
            if (s_bits == 8) begin
                s_byte = next_miso();
                s_bits = 0;
            end
            MISO = s_byte[3'(7 - s_bits)];
        end
    end

    // ---------------- MOSI byte monitor ----------------
    logic [7:0] m_byte = 8'h00;
    int         m_bits = 0;

    always @(negedge nCS) m_bits = 0;

    always @(posedge SCLK) begin
        n_rise++;
        check("sclk_rise_cs_low", {31'd0, nCS}, 32'd0);
        m_byte = {m_byte[6:0], MOSI};
        m_bits++;
        if (m_bits == 8) begin
            m_bits = 0;
            check("mosi_q_nonempty", {31'd0, exp_mosi_q.size() > 0}, 32'd1);
            if (exp_mosi_q.size() > 0) check("mosi_byte", {24'd0, m_byte}, {24'd0, exp_mosi_q.pop_front()});
        end
    end

    // ---------------- cycle monitor: strobes and SCLK timing ----------------
    logic prev_s    = 1'b0;
    logic prev_mosi = 1'b0;
    int   run       = 0;
    int   since_cs  = 0;
    bit   seen_rise = 1'b0;

    always @(negedge clk_16mhz) begin
        if (wr_ready === 1'b1) n_wr++;
        if (rd_valid === 1'b1) begin
            n_rd++;
            check("rd_q_nonempty", {31'd0, exp_rd_q.size() > 0}, 32'd1);
            if (exp_rd_q.size() > 0) check("rd_data", {24'd0, rd_data}, {24'd0, exp_rd_q.pop_front()});
        end
        if (done === 1'b1) begin
            n_done++;
            check("done_after_ncs_high", {31'd0, nCS}, 32'd1);
        end
        if (nCS !== 1'b0) begin
            seen_rise = 1'b0;
            since_cs  = 0;
            run       = 0;
        end else begin
            if (SCLK === prev_s) begin
                run++;
                if (SCLK === 1'b1) check("mosi_stable_high", {31'd0, MOSI}, {31'd0, prev_mosi});
            end else begin
                if (prev_s) check("sclk_high_len", run, CLK_DIV);
                else if (seen_rise) check("sclk_low_len", run, CLK_DIV);
                else check("cs_setup_ok", {31'd0, since_cs >= CS_SETUP}, 32'd1);
                if (SCLK === 1'b1) seen_rise = 1'b1;
                run = 1;
            end
            if (!seen_rise) since_cs++;
        end
        prev_s    = SCLK;
        prev_mosi = MOSI;
    end

    // ---------------- one complete transaction ----------------
    task automatic run_txn(input string name, input logic [7:0] cmd, input logic [5:0] addr,
                           input logic [4:0] len, input logic [31:0] dat, input bit extra_start);
        logic [7:0] b;
        bit         got;
        bit         is_wr;
        is_wr  = (cmd == 8'h0A);
        n_rise = 0;
        n_wr   = 0;
        n_rd   = 0;
        n_done = 0;
        exp_mosi_q.push_back(cmd);
        exp_mosi_q.push_back({2'b00, addr});
        miso_q.push_back(8'h00);
        miso_q.push_back(8'h00);
        for (int i = 0; i < int'(len); i++) begin
            b = dat[8*i +: 8];
            if (is_wr) begin
                exp_mosi_q.push_back(b);
                miso_q.push_back(8'h5A);   // ignored by a write
            end else begin
                exp_mosi_q.push_back(8'h00);
                miso_q.push_back(b);
                exp_rd_q.push_back(b);
            end
        end
        wr_data = dat[7:0];
        @(negedge clk_16mhz);
        command = cmd;
        address = addr;
        length  = len;
        start   = 1'b1;
        @(negedge clk_16mhz);
        start   = 1'b0;
        // Scramble inputs to prove they were latched.
        command = 8'hFF;
        address = 6'h3F;
        length  = 5'h1F;
        check({name, "_busy"}, {31'd0, busy}, 32'd1);
        if (extra_start) begin
            repeat (10) @(negedge clk_16mhz);
            command = 8'h0A;
            length  = 5'd5;
            start   = 1'b1;
            @(negedge clk_16mhz);
            start   = 1'b0;
        end
        got = 1'b0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clk_16mhz);
            if (done === 1'b1) got = 1'b1;
        end
        check({name, "_done_seen"}, {31'd0, got}, 32'd1);
        if (extra_start && got) begin
            start = 1'b1;   // coincides with done, must be ignored
            @(negedge clk_16mhz);
            start = 1'b0;
        end
        repeat (6) @(negedge clk_16mhz);
        check({name, "_rises"}, n_rise, 8 * (2 + int'(len)));
        check({name, "_wr_ready_cnt"}, n_wr, is_wr ? int'(len) : 0);
        check({name, "_rd_valid_cnt"}, n_rd, is_wr ? 0 : int'(len));
        check({name, "_done_cnt"}, n_done, 1);
        check({name, "_mosi_left"}, exp_mosi_q.size(), 0);
        check({name, "_rd_left"}, exp_rd_q.size(), 0);
        check({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_idle_ncs"}, {31'd0, nCS}, 32'd1);
        exp_mosi_q.delete();
        exp_rd_q.delete();
        miso_q.delete();
    endtask

    initial begin
        #(62.5 * 60000);
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit reached;
        rst     = 1'b1;
        start   = 1'b0;
        command = 8'h00;
        address = 6'h00;
        length  = 5'd0;
        wr_data = 8'h00;
        MISO    = 1'b0;
        repeat (3) @(negedge clk_16mhz);
        check("rst_sclk",     {31'd0, SCLK},     32'd0);
        check("rst_mosi",     {31'd0, MOSI},     32'd0);
        check("rst_ncs",      {31'd0, nCS},      32'd1);
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_done",     {31'd0, done},     32'd0);
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_rd_data",  {24'd0, rd_data},  32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk_16mhz);

        run_txn("write", 8'h0A, 6'h1F, 5'd1, 32'h0000_0052, 1'b0);
        run_txn("read",  8'h0B, 6'h00, 5'd1, 32'h0000_00AD, 1'b0);
        run_txn("fifo",  8'h0D, 6'h00, 5'd3, 32'h0033_2211, 1'b0);
        run_txn("hdr",   8'h0B, 6'h05, 5'd0, 32'h0000_0000, 1'b1);

        // Abort in the middle of the address byte.
        n_done = 0;
        n_rise = 0;
        exp_mosi_q.push_back(8'h0B);
        miso_q.push_back(8'h00);
        miso_q.push_back(8'h00);
        @(negedge clk_16mhz);
        command = 8'h0B;
        address = 6'h2A;
        length  = 5'd2;
        start   = 1'b1;
        @(negedge clk_16mhz);
        start   = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 1000 && !reached; c++) begin
            @(negedge clk_16mhz);
            if (n_rise >= 12) reached = 1'b1;
        end
        check("abort_reach_addr", {31'd0, reached}, 32'd1);
        #10;
        rst = 1'b1;
        #1;
        check("abort_ncs",  {31'd0, nCS},  32'd1);
        check("abort_sclk", {31'd0, SCLK}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk_16mhz);
        rst = 1'b0;
        exp_mosi_q.delete();
        exp_rd_q.delete();
        miso_q.delete();
        repeat (10) @(negedge clk_16mhz);
        check("abort_no_done", n_done, 0);
        check("abort_idle_ncs", {31'd0, nCS}, 32'd1);

        run_txn("post_rst", 8'h0B, 6'h2D, 5'd2, 32'h0000_C3E1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
